stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Parametrised stopwatch timekeeping core replacing the fixed six-bit select/adjust path. One clock domain with enable ticks instead of multiple clocks. Holds minutes/seconds counters with run/pause, count direction, and field adjust, plus registered BCD digits for the seven-segment display driver. Sits between the clock-enable divider and the display multiplexer.

## Interface
- MIN_MAX, 59, highest minutes value (≤ 99)
- SEC_MAX, 59, highest seconds value (≤ 99)
- MIN_W, 6, minutes width (≥ clog2(MIN_MAX+1))
- SEC_W, 6, seconds width (≥ clog2(SEC_MAX+1))

- clk  in  1  system clock; all state on posedge
- rst  in  1  reset, synchronous, active-high
- tick_1hz  in  1  one-cycle count enable
- tick_2hz  in  1  one-cycle adjust enable
- adj  in  1  level; 1 = adjust mode
- sel  in  1  level; 1 = adjust seconds, 0 = adjust minutes
- pause  in  1  debounced level; rising edge toggles run/pause
- dir  in  1  0 = count up, 1 = count down
- minutes  out  MIN_W  current minutes, binary
- seconds  out  SEC_W  current seconds, binary
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits
- running  out  1  1 in RUN state
- wrap  out  1  one-cycle pulse on full-range rollover

## Operation
- States: PAUSED, RUN, ADJUST. Reset -> PAUSED, 00:00.
- pause rising edge (registered previous sample, prev cleared by rst): PAUSED<->RUN. Ignored in ADJUST; edge detector keeps sampling so no stale edge on exit.
- adj=1 from PAUSED or RUN -> ADJUST, saving prior state in resume bit; adj=0 -> return to saved state.
- RUN, tick_1hz, dir=0: sec<SEC_MAX -> sec+1; else sec=0, min+1; at MIN_MAX:SEC_MAX -> 00:00, wrap=1.
- RUN, tick_1hz, dir=1: sec>0 -> sec-1; else sec=SEC_MAX, min-1; at 00:00 -> MIN_MAX:SEC_MAX, wrap=1.
- ADJUST, tick_2hz: selected field ±1 per dir, wraps within its own range, no carry into other field, wrap stays 0. Counting frozen.
- PAUSED: counters hold; ticks ignored.
- tick_2hz ignored outside ADJUST; tick_1hz ignored outside RUN.
- Pause edge coincident with tick_1hz in RUN: tick applied, then state -> PAUSED.
- adj rising coincident with tick_1hz: enter ADJUST, tick discarded.
- sel or dir change mid-adjust: takes effect on next tick_2hz.
- BCD: tens = value/10, ones = value%10, from registered binary.

## Timing
- Reset values: minutes=0, seconds=0, all BCD=0, running=0, wrap=0, state PAUSED, resume=PAUSED.
- rst has priority over every input; rst mid-count clears within that edge.
- Binary counters and wrap update on the edge sampling the tick (visible next cycle).
- running updates on the edge sampling the pause edge / adj change.
- BCD digits lag binary by exactly one cycle.
- wrap high exactly one cycle.
- Inputs assumed synchronous to clk; ticks never wider than one cycle.

## Structure
- Package stopwatch_pkg: state enum (PAUSED, RUN, ADJUST), default MIN_MAX/SEC_MAX constants, BCD digit width constant.
- Sub-module bcd_split: combinational 0–99 binary-to-two-digit BCD, instantiated twice; core registers its outputs.

## Test plan
- rst, then five tick_1hz without pause edge -> 00:00, running=0; one pause edge, 3 ticks -> 00:03, running=1, sec_ones=3 one cycle after seconds.
- Preload to 59:59 via adjust, RUN dir=0, one tick_1hz -> 00:00, wrap=1 for one cycle; dir=1 at 00:00, one tick -> 59:59, wrap=1.
- RUN at 12:59, adj=1 sel=1, tick_1hz and four tick_2hz -> 12:03 (no carry, minutes=12); adj=0 -> running=1, counting resumes.
- PAUSED, adj=1 sel=0 dir=1 at 00:10, one tick_2hz -> 59:10; adj=0 -> running=0.
- RUN, pause edge coincident with tick_1hz at 00:07 -> 00:08, running=0; pause pulse during ADJUST -> no state change after exit.
- rst asserted mid-RUN at 34:21 -> next cycle 00:00, running=0, wrap=0, BCD 0 one cycle later.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch timekeeping core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_e;

  localparam logic [1:0] ST_PAUSED = PAUSED;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_ADJUST = ADJUST;

  localparam int DEF_MIN_MAX = 59;
  localparam int DEF_SEC_MAX = 59;
  localparam int BCD_W       = 4;

endpackage

// File: rtl/stopwatch_if.sv
// Control inputs and display outputs of the stopwatch core; master drives controls, slave is the core.
interface stopwatch_if import stopwatch_pkg::*; #(
  parameter int MIN_W = 6,
  parameter int SEC_W = 6
);
  logic             tick_1hz;
  logic             tick_2hz;
  logic             adj;
  logic             sel;
  logic             pause;
  logic             dir;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic [BCD_W-1:0] min_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic             running;
  logic             wrap;

  modport master (
    output tick_1hz, tick_2hz, adj, sel, pause, dir,
    input  minutes, seconds, min_tens, min_ones, sec_tens, sec_ones, running, wrap
  );

  modport slave (
    input  tick_1hz, tick_2hz, adj, sel, pause, dir,
    output minutes, seconds, min_tens, min_ones, sec_tens, sec_ones, running, wrap
  );
endinterface

// File: rtl/stopwatch_bcd_split.sv
// Combinational split of a 0-99 binary value into tens and ones BCD digits.
module bcd_split import stopwatch_pkg::*; #(
  parameter int W = 7
) (
  input  logic [W-1:0]     value,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  assign tens = BCD_W'(value / W'(10));
  assign ones = BCD_W'(value % W'(10));

endmodule

// File: rtl/stopwatch_core.sv
// Minutes/seconds stopwatch with run/pause, up/down counting, field adjust and registered BCD digits.
module stopwatch_core import stopwatch_pkg::*; #(
  parameter int MIN_MAX = DEF_MIN_MAX,
  parameter int SEC_MAX = DEF_SEC_MAX,
  parameter int MIN_W   = 6,
  parameter int SEC_W   = 6
) (
  input logic        clk,
  input logic        rst,
  stopwatch_if.slave sw
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);
  localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

  logic [1:0]       state, state_n;
  logic             resume_run, resume_n;
  logic             pause_prev;
  logic             pause_edge;
  logic [MIN_W-1:0] minutes, min_n;
  logic [SEC_W-1:0] seconds, sec_n;
  logic             wrap, wrap_n;
  logic [BCD_W-1:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [BCD_W-1:0] min_tens_c, min_ones_c, sec_tens_c, sec_ones_c;

  assign pause_edge = sw.pause & ~pause_prev;

  // adj beats both ticks and pause edges; a tick in the adj-entry cycle is dropped
  always_comb begin
    state_n  = state;
    resume_n = resume_run;
    min_n    = minutes;
    sec_n    = seconds;
    wrap_n   = 1'b0;
    case (state)
      ST_PAUSED: begin
        if (sw.adj) begin
          state_n  = ST_ADJUST;
          resume_n = 1'b0;
        end else if (pause_edge) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sw.adj) begin
          state_n  = ST_ADJUST;
          resume_n = 1'b1;
        end else begin
          if (sw.tick_1hz) begin
            if (!sw.dir) begin
              if (seconds < SEC_TOP) begin
                sec_n = seconds + SEC_ONE;
              end else begin
                sec_n = '0;
                if (minutes < MIN_TOP) begin
                  min_n = minutes + MIN_ONE;
                end else begin
                  min_n  = '0;
                  wrap_n = 1'b1;
                end
              end
            end else begin
              if (seconds != '0) begin
                sec_n = seconds - SEC_ONE;
              end else begin
                sec_n = SEC_TOP;
                if (minutes != '0) begin
                  min_n = minutes - MIN_ONE;
                end else begin
                  min_n  = MIN_TOP;
                  wrap_n = 1'b1;
                end
              end
            end
          end
          if (pause_edge) state_n = ST_PAUSED;
        end
      end
      ST_ADJUST: begin
        if (sw.tick_2hz) begin
          if (sw.sel) begin
            if (!sw.dir) sec_n = (seconds == SEC_TOP) ? '0 : seconds + SEC_ONE;
            else         sec_n = (seconds == '0) ? SEC_TOP : seconds - SEC_ONE;
          end else begin
            if (!sw.dir) min_n = (minutes == MIN_TOP) ? '0 : minutes + MIN_ONE;
            else         min_n = (minutes == '0) ? MIN_TOP : minutes - MIN_ONE;
          end
        end
        if (!sw.adj) state_n = resume_run ? ST_RUN : ST_PAUSED;
      end
      default: state_n = ST_PAUSED;
    endcase
  end

  bcd_split #(.W(MIN_W)) u_min_split (.value(minutes), .tens(min_tens_c), .ones(min_ones_c));
  bcd_split #(.W(SEC_W)) u_sec_split (.value(seconds), .tens(sec_tens_c), .ones(sec_ones_c));

  // BCD registers sample the current binary, so digits trail the counters by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PAUSED;
      resume_run <= 1'b0;
      pause_prev <= 1'b0;
      minutes    <= '0;
      seconds    <= '0;
      wrap       <= 1'b0;
      min_tens   <= '0;
      min_ones   <= '0;
      sec_tens   <= '0;
      sec_ones   <= '0;
    end else begin
      state      <= state_n;
      resume_run <= resume_n;
      pause_prev <= sw.pause;
      minutes    <= min_n;
      seconds    <= sec_n;
      wrap       <= wrap_n;
      min_tens   <= min_tens_c;
      min_ones   <= min_ones_c;
      sec_tens   <= sec_tens_c;
      sec_ones   <= sec_ones_c;
    end
  end

  assign sw.minutes  = minutes;
  assign sw.seconds  = seconds;
  assign sw.min_tens = min_tens;
  assign sw.min_ones = min_ones;
  assign sw.sec_tens = sec_tens;
  assign sw.sec_ones = sec_ones;
  assign sw.running  = (state == ST_RUN);
  assign sw.wrap     = wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed vector table, hand-written corner sequences, randomized run vs. reference model.
module tb_stopwatch_core;

  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int M_PAUSED = 0;
  localparam int M_RUN    = 1;
  localparam int M_ADJUST = 2;

  logic clk = 1'b0;
  logic rst;

  stopwatch_if #(.MIN_W(MIN_W), .SEC_W(SEC_W)) sw ();

  stopwatch_core #(
    .MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX), .MIN_W(MIN_W), .SEC_W(SEC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, t1, t2, adj, sel, pause, dir;
    int   e_min, e_sec;
    logic e_run, e_wrap;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time as a single count of seconds in the full range
  int m_min, m_sec, m_mode, m_resume, m_pprev, m_bmin, m_bsec;
  logic m_wrap;

  logic r_rst, r_t1 = 1'b0, r_t2 = 1'b0, r_adj = 1'b0, r_sel = 1'b0, r_p = 1'b0, r_dir = 1'b0;

  function automatic vec_t mk(logic r, t1, t2, adj, sel, pause, dir,
                              int mn, sc, logic run, wr);
    vec_t v;
    v.r = r; v.t1 = t1; v.t2 = t2; v.adj = adj; v.sel = sel; v.pause = pause; v.dir = dir;
    v.e_min = mn; v.e_sec = sc; v.e_run = run; v.e_wrap = wr;
    return v;
  endfunction

  function automatic void model_step(logic r, t1, t2, adj, sel, pause, dir);
    int period, tot;
    logic pause_rise;
    period = (MIN_MAX + 1) * (SEC_MAX + 1);
    if (r) begin
      m_min = 0; m_sec = 0; m_mode = M_PAUSED; m_resume = M_PAUSED;
      m_pprev = 0; m_wrap = 1'b0; m_bmin = 0; m_bsec = 0;
      return;
    end
    pause_rise = pause && (m_pprev == 0);
    m_pprev = int'(pause);
    m_bmin = m_min;
    m_bsec = m_sec;
    m_wrap = 1'b0;
    if (m_mode == M_PAUSED) begin
      if (adj) begin m_mode = M_ADJUST; m_resume = M_PAUSED; end
      else if (pause_rise) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (adj) begin
        m_mode = M_ADJUST; m_resume = M_RUN;
      end else begin
        if (t1) begin
          tot = m_min * (SEC_MAX + 1) + m_sec;
          if (!dir) begin
            m_wrap = (tot == period - 1);
            tot = (tot + 1) % period;
          end else begin
            m_wrap = (tot == 0);
            tot = (tot + period - 1) % period;
          end
          m_min = tot / (SEC_MAX + 1);
          m_sec = tot % (SEC_MAX + 1);
        end
        if (pause_rise) m_mode = M_PAUSED;
      end
    end else begin
      if (t2) begin
        if (sel) m_sec = (m_sec + (dir ? SEC_MAX : 1)) % (SEC_MAX + 1);
        else     m_min = (m_min + (dir ? MIN_MAX : 1)) % (MIN_MAX + 1);
      end
      if (!adj) m_mode = m_resume;
    end
  endfunction

  task automatic cycle(input logic r, t1, t2, adj, sel, pause, dir);
    rst = r;
    sw.tick_1hz = t1; sw.tick_2hz = t2; sw.adj = adj;
    sw.sel = sel; sw.pause = pause; sw.dir = dir;
    @(posedge clk);
    model_step(r, t1, t2, adj, sel, pause, dir);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int e_min, e_sec, input logic e_run, e_wrap);
    check({tag, " minutes"},  32'(sw.minutes),  e_min);
    check({tag, " seconds"},  32'(sw.seconds),  e_sec);
    check({tag, " running"},  32'(sw.running),  32'(e_run));
    check({tag, " wrap"},     32'(sw.wrap),     32'(e_wrap));
    check({tag, " min_tens"}, 32'(sw.min_tens), m_bmin / 10);
    check({tag, " min_ones"}, 32'(sw.min_ones), m_bmin % 10);
    check({tag, " sec_tens"}, 32'(sw.sec_tens), m_bsec / 10);
    check({tag, " sec_ones"}, 32'(sw.sec_ones), m_bsec % 10);
  endtask

  // One vector cycle, then a tick-free cycle with the same levels to catch wrap width and BCD lag
  task automatic applyStimulus(input string tag, input vec_t v);
    cycle(v.r, v.t1, v.t2, v.adj, v.sel, v.pause, v.dir);
    checkOutput(tag, v.e_min, v.e_sec, v.e_run, v.e_wrap);
    cycle(1'b0, 1'b0, 1'b0, v.adj, v.sel, v.pause, v.dir);
    checkOutput({tag, "+1"}, v.e_min, v.e_sec, v.e_run, 1'b0);
  endtask

  vec_t tbl [18];

  initial begin
    //             r  t1 t2 adj sel p  dir  min sec run wrap
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0,   0,  0, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  1, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  2, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0,   0,  3, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 0, 1,   0,  0, 0, 0);
    tbl[12] = mk(0, 0, 1, 1, 0, 0, 1,  59,  0, 0, 0);
    tbl[13] = mk(0, 0, 1, 1, 1, 0, 1,  59, 59, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  59, 59, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 0,  59, 59, 1, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 1, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 1,  59, 59, 1, 1);

    for (int i = 0; i < 18; i++) applyStimulus($sformatf("vec%0d", i), tbl[i]);

    // No carry out of the adjusted field; tick_1hz on the adj-entry cycle is discarded
    applyStimulus("nc_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("nc_adj", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 12; i++) applyStimulus("nc_min", mk(0, 0, 1, 1, 0, 0, 0, i, 0, 0, 0));
    applyStimulus("nc_sec", mk(0, 0, 1, 1, 1, 0, 1, 12, 59, 0, 0));
    applyStimulus("nc_exit", mk(0, 0, 0, 0, 1, 0, 1, 12, 59, 0, 0));
    applyStimulus("nc_run", mk(0, 0, 0, 0, 1, 1, 0, 12, 59, 1, 0));
    applyStimulus("nc_adjtick", mk(0, 1, 0, 1, 1, 0, 0, 12, 59, 0, 0));
    for (int i = 0; i < 4; i++) applyStimulus("nc_up", mk(0, 0, 1, 1, 1, 0, 0, 12, i, 0, 0));
    applyStimulus("nc_resume", mk(0, 0, 0, 0, 1, 0, 0, 12, 3, 1, 0));
    applyStimulus("nc_count", mk(0, 1, 0, 0, 1, 0, 0, 12, 4, 1, 0));

    // Pause edge together with a tick, then adjust from PAUSED with pause activity inside ADJUST
    applyStimulus("pt_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("pt_run", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 7; i++) applyStimulus("pt_tick", mk(0, 1, 0, 0, 0, 0, 0, 0, i, 1, 0));
    applyStimulus("pt_both", mk(0, 1, 0, 0, 0, 1, 0, 0, 8, 0, 0));
    applyStimulus("pt_adj", mk(0, 0, 0, 1, 1, 1, 0, 0, 8, 0, 0));
    for (int i = 9; i <= 10; i++) applyStimulus("pt_sec", mk(0, 0, 1, 1, 1, 1, 0, 0, i, 0, 0));
    applyStimulus("pt_mindn", mk(0, 0, 1, 1, 0, 0, 1, 59, 10, 0, 0));
    applyStimulus("pt_prise", mk(0, 0, 0, 1, 0, 1, 1, 59, 10, 0, 0));
    applyStimulus("pt_exit", mk(0, 0, 0, 0, 0, 1, 1, 59, 10, 0, 0));
    applyStimulus("pt_idle", mk(0, 0, 0, 0, 0, 0, 0, 59, 10, 0, 0));

    // Reset in the middle of a run at 34:21, coincident with a count tick
    applyStimulus("mr_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("mr_adj", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 34; i++) applyStimulus("mr_min", mk(0, 0, 1, 1, 0, 0, 0, i, 0, 0, 0));
    for (int i = 1; i <= 21; i++) applyStimulus("mr_sec", mk(0, 0, 1, 1, 1, 0, 0, 34, i, 0, 0));
    applyStimulus("mr_exit", mk(0, 0, 0, 0, 0, 0, 0, 34, 21, 0, 0));
    applyStimulus("mr_run", mk(0, 0, 0, 0, 0, 1, 0, 34, 21, 1, 0));
    applyStimulus("mr_clear", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic against the reference model
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rand_rst", m_min, m_sec, m_mode == M_RUN, m_wrap);
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_t1  = !r_t1 && ($urandom_range(0, 1) == 0);
      r_t2  = !r_t2 && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) r_adj = !r_adj;
      if ($urandom_range(0, 11) == 0) r_p   = !r_p;
      if ($urandom_range(0, 9) == 0)  r_sel = !r_sel;
      if ($urandom_range(0, 29) == 0) r_dir = !r_dir;
      cycle(r_rst, r_t1, r_t2, r_adj, r_sel, r_p, r_dir);
      checkOutput("rand", m_min, m_sec, m_mode == M_RUN, m_wrap);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
